// File: rtl/bfloat_mac_ctrl.sv
// Sequencer for an external bfloat16 multiply-accumulate unit: clears the accumulator,
// streams cfg_len operand pairs into it, waits out the MAC latency and captures the sum.
// Ports: start/abort/cfg_len control; in_* operand stream with valid/ready; mac_* drive the
// MAC and mac_c returns its accumulator; res_* result with valid/ready; busy/done status.
module bfloat_mac_ctrl #(
    parameter int MAC_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_en,
    output logic             mac_clr,
    input  logic [15:0]      mac_c,
    output logic             res_valid,
    output logic [15:0]      res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, DRAIN, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [DW-1:0]    dcnt;
    logic             last_pair;

    // len is never 0 inside a run, so len-1 cannot underflow and cnt tops out at len.
    assign last_pair = (cnt == len - CNT_W'(1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            dcnt      <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                // Takes priority over every other input sampled on this edge.
                state     <= IDLE;
                cnt       <= '0;
                in_ready  <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && (cfg_len != '0)) begin
                            len     <= cfg_len;
                            cnt     <= '0;
                            mac_clr <= 1'b1;
                            state   <= CLR;
                        end
                    end
                    CLR: begin
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                    LOAD: begin
                        // No timeout: an in_valid gap simply holds the state.
                        if (in_valid) begin
                            mac_a  <= in_a;
                            mac_b  <= in_b;
                            mac_en <= 1'b1;
                            cnt    <= cnt + CNT_W'(1);
                            if (last_pair) begin
                                in_ready <= 1'b0;
                                dcnt     <= DW'(MAC_LAT);
                                state    <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        // The first DRAIN cycle carries the final mac_en; MAC_LAT more
                        // cycles later the accumulator holds the complete sum.
                        if (dcnt == '0) begin
                            res_data  <= mac_c;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            dcnt <= dcnt - DW'(1);
                        end
                    end
                    HOLD: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
